// File: rtl/swt16_pkg.sv
// Shared constants for the swt16 pipeline: datapath widths and the
// memory-access stage handshake states.
package swt16_pkg;

    localparam int SWT_DMEM_ADDR_W = 12;
    localparam int SWT_DMEM_WORD_W = 16;
    localparam int SWT_IALU_WORD_W = 16;
    localparam int SWT_PC_W        = 12;
    localparam int SWT_PMEM_WORD_W = 16;
    localparam int SWT_REG_IDX_W   = 4;
    localparam int SWT_STALL_CNT_W = 16;

    // IDLE: no access outstanding; WAIT: access issued, ack not yet seen
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/memory_access.sv
// Memory-access pipeline stage: latches the execute results, issues a single
// data-memory request per load/store, stalls upstream until the memory acks,
// and forwards load data to writeback with zero latency from the ack.
module memory_access
    import swt16_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = SWT_DMEM_ADDR_W,
    parameter int DMEM_WORD_WIDTH = SWT_DMEM_WORD_W,
    parameter int IALU_WORD_WIDTH = SWT_IALU_WORD_W,
    parameter int PC_WIDTH        = SWT_PC_W,
    parameter int PMEM_WORD_WIDTH = SWT_PMEM_WORD_W,
    parameter int REG_IDX_WIDTH   = SWT_REG_IDX_W
) (
    input  logic                       clock,
    input  logic                       reset,

    input  logic                       in_act_load_dmem,
    input  logic                       in_act_store_dmem,
    input  logic                       in_act_write_res_to_reg,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
    input  logic [IALU_WORD_WIDTH-1:0] in_res,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,

    output logic                       out_dmem_req,
    output logic                       out_dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_addr,
    output logic [DMEM_WORD_WIDTH-1:0] out_dmem_wdata,
    input  logic                       in_dmem_ack,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_rdata,

    output logic                       out_act_write_res_to_reg,
    output logic [IALU_WORD_WIDTH-1:0] out_res,
    output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
    output logic [PMEM_WORD_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic                       out_res_valid,
    output logic                       out_stall,
    output logic [SWT_STALL_CNT_W-1:0] out_stall_count
);

    // stage registers
    logic                       load_ff;
    logic                       store_ff;
    logic                       write_ff;
    logic [DMEM_ADDR_WIDTH-1:0] rd_addr_ff;
    logic [DMEM_ADDR_WIDTH-1:0] wr_addr_ff;
    logic [DMEM_WORD_WIDTH-1:0] wr_word_ff;
    logic [IALU_WORD_WIDTH-1:0] res_ff;
    logic [REG_IDX_WIDTH-1:0]   res_reg_idx_ff;
    logic [PMEM_WORD_WIDTH-1:0] instr_ff;
    logic [PC_WIDTH-1:0]        pc_ff;

    mem_state_t state;

    logic mem_op;
    logic is_load;
    logic req;
    logic stall;
    logic load_done;

    // A store wins when both flags are set; the load half is dropped.
    assign mem_op  = load_ff | store_ff;
    assign is_load = load_ff & ~store_ff;

    // Request/stall decode; state and stage regs reset asynchronously, so a
    // reset mid-WAIT drops the request without waiting for a clock.
    always_comb begin
        req       = (state == ST_WAIT) | mem_op;
        stall     = req & ~in_dmem_ack;
        load_done = req & is_load & in_dmem_ack;
    end

    // Stage registers: capture execute outputs unless the stage is stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_ff        <= 1'b0;
            store_ff       <= 1'b0;
            write_ff       <= 1'b0;
            rd_addr_ff     <= '0;
            wr_addr_ff     <= '0;
            wr_word_ff     <= '0;
            res_ff         <= '0;
            res_reg_idx_ff <= '0;
            instr_ff       <= '0;
            pc_ff          <= '0;
        end else if (!stall) begin
            load_ff        <= in_act_load_dmem;
            store_ff       <= in_act_store_dmem;
            write_ff       <= in_act_write_res_to_reg;
            rd_addr_ff     <= in_dmem_rd_addr;
            wr_addr_ff     <= in_dmem_wr_addr;
            wr_word_ff     <= in_dmem_wr_word;
            res_ff         <= in_res;
            res_reg_idx_ff <= in_res_reg_idx;
            instr_ff       <= in_instr;
            pc_ff          <= in_pc;
        end
    end

    // Handshake FSM: an immediately acked access never leaves IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (mem_op && !in_dmem_ack) state <= ST_WAIT;
                ST_WAIT: if (in_dmem_ack)            state <= ST_IDLE;
                default:                             state <= ST_IDLE;
            endcase
        end
    end

    // Stall-cycle counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            out_stall_count <= '0;
        else if (stall && (out_stall_count != {SWT_STALL_CNT_W{1'b1}}))
            out_stall_count <= out_stall_count + 1'b1;
    end

    // Output mux: memory-side fields are zeroed whenever no access is requested.
    always_comb begin
        out_dmem_req   = req;
        out_dmem_we    = req & store_ff;
        out_dmem_addr  = '0;
        out_dmem_wdata = '0;
        if (req) begin
            out_dmem_addr  = store_ff ? wr_addr_ff : rd_addr_ff;
            out_dmem_wdata = store_ff ? wr_word_ff : '0;
        end
        out_stall                = stall;
        out_res                  = load_done ? in_dmem_rdata : res_ff;
        out_act_write_res_to_reg = write_ff & ~stall & ~store_ff;
        out_res_valid            = write_ff & ~stall & ~store_ff;
        out_res_reg_idx          = res_reg_idx_ff;
        out_instr                = instr_ff;
        out_pc                   = pc_ff;
    end

endmodule
